// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [7:0] DEF_START_BYTE = 8'hA5;
  localparam int         MAX_LEN        = 256;

endpackage

// File: rtl/loader_csum.sv
// 8-bit modulo-256 checksum accumulator for the program loader.
module loader_csum
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] add_data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader that writes a framed image into RAM.
// Optional checksum byte enabled with PROG_LOADER_CSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] BASE_ADDR  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  state_t     state;
  logic [8:0] remaining;
  logic [7:0] addr;
  logic       xfer;

  assign in_ready = (state != S_DONE);
  assign xfer     = in_valid && in_ready;

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] sum;
  logic       err_q;

  loader_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == S_LEN && xfer),
    .add_en   (state == S_DATA && xfer),
    .add_data (in_data),
    .sum      (sum)
  );

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= 9'd0;
      addr      <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      err_q     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (xfer && in_data == START_BYTE) begin
            state <= S_LEN;
`ifdef PROG_LOADER_CSUM_EN
            err_q <= 1'b0;
`endif
          end
        end
        S_LEN: begin
          if (xfer) begin
            // A length byte of zero encodes a full 256-byte image
            remaining <= (in_data == 8'h00) ? 9'(MAX_LEN)
                                            : {1'b0, in_data};
            addr      <= BASE_ADDR;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            addr      <= addr + 8'd1;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
`ifdef PROG_LOADER_CSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (in_data == sum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_IDLE;
              err_q <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_hold;
  logic       done;
  logic       error;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back('{cyc, mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
  endtask

  initial begin
    int bad;
    int nwr;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Basic 3-byte frame, back-to-back
    wq.delete();
    send(8'hA5); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
`ifdef PROG_LOADER_CSUM_EN
    send(8'h66);
`endif
    idle(3);
    chk("f3_nwr", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk("f3_a0", 32'(wq[0].a), 32'h00);
      chk("f3_d0", 32'(wq[0].d), 32'h11);
      chk("f3_a1", 32'(wq[1].a), 32'h01);
      chk("f3_d1", 32'(wq[1].d), 32'h22);
      chk("f3_a2", 32'(wq[2].a), 32'h02);
      chk("f3_d2", 32'(wq[2].d), 32'h33);
      chk("f3_gap1", 32'(wq[1].cyc - wq[0].cyc), 32'd1);
      chk("f3_gap2", 32'(wq[2].cyc - wq[1].cyc), 32'd1);
    end
    chk("f3_done", 32'(done), 32'd1);
    chk("f3_hold", 32'(cpu_hold), 32'd0);
    chk("f3_ready", 32'(in_ready), 32'd0);
    chk("f3_err", 32'(error), 32'd0);

`ifdef PROG_LOADER_CSUM_EN
    // Bad checksum rejected, good frame follows
    do_reset();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(2);
    chk("bad_err", 32'(error), 32'd1);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_ready", 32'(in_ready), 32'd1);
    chk("bad_nwr", 32'(wq.size()), 32'd2);
    wq.delete();
    send(8'hA5);
    chk("bad_errclr", 32'(error), 32'd0);
    send(8'h01); send(8'h7F); send(8'h7F);
    idle(2);
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_nwr", 32'(wq.size()), 32'd1);
`endif

    // Leading junk discarded
    do_reset();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h42);
`ifdef PROG_LOADER_CSUM_EN
    send(8'h42);
`endif
    idle(2);
    chk("junk_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      chk("junk_a", 32'(wq[0].a), 32'h00);
      chk("junk_d", 32'(wq[0].d), 32'h42);
    end
    chk("junk_done", 32'(done), 32'd1);

    // Full 256-byte image
    do_reset();
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
`ifdef PROG_LOADER_CSUM_EN
    send(8'h80);
`endif
    idle(2);
    chk("full_nwr", 32'(wq.size()), 32'd256);
    bad = 0;
    nwr = wq.size();
    for (int i = 0; i < nwr; i++) begin
      if (wq[i].a !== 8'(i) || wq[i].d !== 8'(i)) bad++;
    end
    chk("full_content", 32'(bad), 32'd0);
    if (nwr == 256) chk("full_last_a", 32'(wq[255].a), 32'hFF);
    chk("full_done", 32'(done), 32'd1);

    // Reset mid-frame, with a pending transfer held during reset
    do_reset();
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    in_data  = 8'h03;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_nwr", 32'(wq.size()), 32'd2);
    wq.delete();
    send(8'hA5); send(8'h01); send(8'h55);
`ifdef PROG_LOADER_CSUM_EN
    send(8'h55);
`endif
    idle(2);
    chk("mid2_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      chk("mid2_a", 32'(wq[0].a), 32'h00);
      chk("mid2_d", 32'(wq[0].d), 32'h55);
    end
    chk("mid2_done", 32'(done), 32'd1);

    // Gappy valid during data, then input ignored after done
    do_reset();
    send(8'hA5); send(8'h05);
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 3));
      send(8'(9 - i));
    end
`ifdef PROG_LOADER_CSUM_EN
    idle(2);
    send(8'h23);
`endif
    idle(2);
    chk("gap_nwr", 32'(wq.size()), 32'd5);
    bad = 0;
    nwr = wq.size();
    for (int i = 0; i < nwr; i++) begin
      if (wq[i].a !== 8'(i) || wq[i].d !== 8'(9 - i)) bad++;
    end
    chk("gap_content", 32'(bad), 32'd0);
    chk("gap_done", 32'(done), 32'd1);
    wq.delete();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_ready", 32'(in_ready), 32'd0);
    chk("post_nwr", 32'(wq.size()), 32'd0);
    chk("post_done", 32'(done), 32'd1);
    chk("post_hold", 32'(cpu_hold), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter START_BYTE, default 8'hA5, frame start marker.
REQ-002 The module SHALL have parameter BASE_ADDR, default 8'h00, RAM address written by the first data byte.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  8  incoming byte from the host link.
REQ-006 Port: in_valid  input  1  in_data is valid.
REQ-007 Port: in_ready  output  1  loader accepts the byte; a transfer occurs on a clock edge with in_valid && in_ready.
REQ-008 Port: mem_addr  output  8  RAM write address.
REQ-009 Port: mem_wdata  output  8  RAM write data.
REQ-010 Port: mem_we  output  1  RAM write strobe, one cycle per data byte.
REQ-011 Port: cpu_hold  output  1  holds the CPU in reset while high.
REQ-012 Port: done  output  1  program loaded successfully; sticky until reset.
REQ-013 Port: error  output  1  last frame was rejected; sticky until the next START_BYTE is accepted or reset.

Function
REQ-014 Frame format: START_BYTE, LEN, LEN data bytes, then CSUM when checksum is compiled in; LEN=0 means 256 bytes.
REQ-015 The state machine SHALL have the states IDLE, LEN, DATA, CSUM, DONE.
REQ-016 IDLE: in_ready=1; an accepted byte equal to START_BYTE moves to LEN and clears error; any other accepted byte is discarded.
REQ-017 LEN: the accepted byte loads an 9-bit remaining count (0 maps to 256), addr is set to BASE_ADDR, the checksum is cleared, and the state moves to DATA.
REQ-018 DATA: each accepted byte SHALL produce mem_we=1 in the following cycle, with registered mem_addr=addr and mem_wdata=byte; addr increments mod 256 and remaining decrements.
REQ-019 Back-to-back accepts SHALL produce mem_we on consecutive cycles with no bubble.
REQ-020 Accepting the last data byte SHALL move to CSUM, or to DONE when checksum is compiled out.
REQ-021 CSUM: if the accepted byte equals the 8-bit sum mod 256 of the data bytes, the state moves to DONE; otherwise it moves to IDLE with error=1.
REQ-022 DONE: done=1 and cpu_hold=0 from the first cycle in DONE; in_ready=0; all further input is ignored until reset.
REQ-023 cpu_hold SHALL be 1 in every state except DONE.
REQ-024 A rejected frame SHALL leave written RAM bytes in place and SHALL keep cpu_hold=1.
REQ-025 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-026 Reset SHALL return state to IDLE, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, and clear count and checksum.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no mem_we in the cycle after reset.
REQ-028 Reset SHALL take priority over an in_valid transfer in the same cycle.

Configuration
REQ-029 With PROG_LOADER_CSUM_EN defined, the CSUM state and the checksum check SHALL be present.
REQ-030 Without PROG_LOADER_CSUM_EN, no checksum byte is expected, the CSUM state is absent, and error SHALL be tied to 0.

Structure
REQ-031 A shared package loader_pkg SHALL hold the state enum type, the default START_BYTE constant, and the 256-byte maximum-length constant.
REQ-032 The checksum accumulator SHALL be a sub-module named loader_csum, with clear, add-enable, and 8-bit sum output.

Verification
REQ-033 With checksum enabled, send A5,03,11,22,33,66 -> mem_we on 3 consecutive cycles at addresses 00/01/02 with data 11/22/33, then done=1 and cpu_hold=0.
REQ-034 Send A5,02,10,20,00 -> error=1, cpu_hold=1, state IDLE; then send A5,01,7F,7F -> done=1.
REQ-035 Send 00,FF,A5,01,42,42 -> the leading 00 and FF are discarded, with a single write of 42 to address 00.
REQ-036 Send A5,00 followed by 256 bytes of value i, then the correct checksum 80 -> 256 writes, the last to address FF, then done=1.
REQ-037 Assert reset after 2 of 4 data bytes -> the next cycle shows mem_we=0, cpu_hold=1, done=0, and a fresh frame then loads correctly.
REQ-038 Toggle in_valid randomly during DATA -> writes occur only for accepted bytes; after done, in_ready=0 and further bytes cause no mem_we.
